// File: rtl/hilo_reg_pipe_if.sv
// rtl/hilo_reg_pipe_if.sv - EX-side HI/LO write request and read-back bundle
interface hilo_reg_pipe_if;
    logic        we_e;
    logic [63:0] hilo_e;
    logic        stall_e;
    logic        flush_e;
    logic        flush_m;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hazard_o;
    logic        busy_o;

    // Pipeline control / EX side that issues writes and consumes HI/LO
    modport master (
        output we_e,
        output hilo_e,
        output stall_e,
        output flush_e,
        output flush_m,
        input  hi_o,
        input  lo_o,
        input  hazard_o,
        input  busy_o
    );

    // The HI/LO register pipe itself
    modport slave (
        input  we_e,
        input  hilo_e,
        input  stall_e,
        input  flush_e,
        input  flush_m,
        output hi_o,
        output lo_o,
        output hazard_o,
        output busy_o
    );
endinterface

// File: rtl/hilo_reg_pipe.sv
// rtl/hilo_reg_pipe.sv - HI/LO register with M/W write pipeline; HILO_FWD_EN enables forwarding
module hilo_reg_pipe (
    input  logic            clk,
    input  logic            rst,
    hilo_reg_pipe_if.slave  bus
);

    logic        valid_m;
    logic [63:0] data_m;
    logic        valid_w;
    logic [63:0] data_w;
    logic [63:0] arch;

    logic        capture;
    logic        advance;
    logic [63:0] read_sel;

    // A write enters M only from a live, unstalled EX entry and never while MEM is being flushed
    assign capture = bus.we_e & ~bus.stall_e & ~bus.flush_e & ~bus.flush_m;
    // The M entry is lost if MEM is flushed; W is past the flush point and always commits
    assign advance = valid_m & ~bus.flush_m;

    // M stage: capture accepted EX writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_m <= 1'b0;
            data_m  <= 64'd0;
        end else begin
            valid_m <= capture;
            if (capture) begin
                data_m <= bus.hilo_e;
            end
        end
    end

    // W stage: move surviving M entries forward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_w <= 1'b0;
            data_w  <= 64'd0;
        end else begin
            valid_w <= advance;
            if (advance) begin
                data_w <= data_m;
            end
        end
    end

    // Architectural HI/LO: commit W entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arch <= 64'd0;
        end else if (valid_w) begin
            arch <= data_w;
        end
    end

    // Read value seen by EX; hilo_e is never bypassed so EX cannot read its own write
    always_comb begin
        read_sel = arch;
`ifdef HILO_FWD_EN
        if (valid_m) begin
            read_sel = data_m;
        end else if (valid_w) begin
            read_sel = data_w;
        end
`endif
    end

    assign bus.hi_o   = read_sel[63:32];
    assign bus.lo_o   = read_sel[31:0];
    assign bus.busy_o = valid_m | valid_w;

`ifdef HILO_FWD_EN
    assign bus.hazard_o = 1'b0;
`else
    // Without forwarding any in-flight write makes the architectural value stale
    assign bus.hazard_o = valid_m | valid_w;
`endif

endmodule

// File: tb/tb_hilo_reg_pipe.sv
// tb/tb_hilo_reg_pipe.sv - directed scoreboard bench for hilo_reg_pipe
module tb_hilo_reg_pipe;

`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        hazard;
    } exp_t;

    logic clk;
    logic rst;
    hilo_reg_pipe_if bus ();

    hilo_reg_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_run;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation; fwd_* is the value read with forwarding, arch_* without
    task automatic expect_out(input string tag,
                              input logic [31:0] fwd_hi, input logic [31:0] fwd_lo,
                              input logic [31:0] arch_hi, input logic [31:0] arch_lo,
                              input logic busy);
        exp_t e;
        e.tag    = tag;
        e.hi     = FWD ? fwd_hi : arch_hi;
        e.lo     = FWD ? fwd_lo : arch_lo;
        e.busy   = busy;
        e.hazard = FWD ? 1'b0 : busy;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 0 entries required 1");
            return;
        end
        e = exp_q.pop_front();
        n_run += 3;
        assert (bus.hi_o === e.hi) else begin
            n_fail++;
            $error("FAIL %s hi_o: got %h required %h", e.tag, bus.hi_o, e.hi);
        end
        assert (bus.lo_o === e.lo) else begin
            n_fail++;
            $error("FAIL %s lo_o: got %h required %h", e.tag, bus.lo_o, e.lo);
        end
        assert (bus.busy_o === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy_o: got %b required %b", e.tag, bus.busy_o, e.busy);
        end
        assert (bus.hazard_o === e.hazard) else begin
            n_fail++;
            $error("FAIL %s hazard_o: got %b required %b", e.tag, bus.hazard_o, e.hazard);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, clock it, sample 1ns later
    task automatic step(input logic we, input logic [63:0] data,
                        input logic stall, input logic fe, input logic fm);
        @(negedge clk);
        bus.we_e    = we;
        bus.hilo_e  = data;
        bus.stall_e = stall;
        bus.flush_e = fe;
        bus.flush_m = fm;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle();
        step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.we_e    = 1'b0;
        bus.hilo_e  = 64'd0;
        bus.stall_e = 1'b0;
        bus.flush_e = 1'b0;
        bus.flush_m = 1'b0;

        // Reset state, then first cycles after release with no writes
        #2;
        expect_out("in_reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_out();
        @(negedge clk);
        rst = 1'b0;
        expect_out("post_reset_idle", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();

        // Single write flows M -> W -> arch
        expect_out("w1_m", 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        expect_out("w1_w", 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b1);
        idle();
        expect_out("w1_arch", 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        idle();
        expect_out("w1_hold", 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        idle();

        // Back-to-back writes: youngest wins
        expect_out("b2b_a", 32'h1, 32'h2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        step(1'b1, 64'h0000_0001_0000_0002, 1'b0, 1'b0, 1'b0);
        expect_out("b2b_b", 32'h3, 32'h4, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        step(1'b1, 64'h0000_0003_0000_0004, 1'b0, 1'b0, 1'b0);
        expect_out("b2b_drain", 32'h3, 32'h4, 32'h1, 32'h2, 1'b1);
        idle();
        expect_out("b2b_arch", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0);
        idle();

        // MEM flush kills the entry sitting in M
        expect_out("fm_accept", 32'hAAAA, 32'hBBBB, 32'h3, 32'h4, 1'b1);
        step(1'b1, 64'h0000_AAAA_0000_BBBB, 1'b0, 1'b0, 1'b0);
        expect_out("fm_killed", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        expect_out("fm_after", 32'h3, 32'h4, 32'h3, 32'h4, 1'b0);
        idle();

        // MEM flush with a concurrent EX write: W entry still commits, EX write dropped
        expect_out("fmw_c_m", 32'h5, 32'h6, 32'h3, 32'h4, 1'b1);
        step(1'b1, 64'h0000_0005_0000_0006, 1'b0, 1'b0, 1'b0);
        expect_out("fmw_c_w", 32'h5, 32'h6, 32'h3, 32'h4, 1'b1);
        idle();
        expect_out("fmw_commit", 32'h5, 32'h6, 32'h5, 32'h6, 1'b0);
        step(1'b1, 64'h0000_0007_0000_0008, 1'b0, 1'b0, 1'b1);

        // Long EX stall: nothing captured, then captured once stall drops
        for (int i = 0; i < 5; i++) begin
            expect_out("stall_hold", 32'h5, 32'h6, 32'h5, 32'h6, 1'b0);
            step(1'b1, 64'h0000_0009_0000_000A, 1'b1, 1'b0, 1'b0);
        end
        expect_out("stall_release", 32'h9, 32'hA, 32'h5, 32'h6, 1'b1);
        step(1'b1, 64'h0000_0009_0000_000A, 1'b0, 1'b0, 1'b0);
        expect_out("stall_w", 32'h9, 32'hA, 32'h5, 32'h6, 1'b1);
        idle();
        expect_out("stall_arch", 32'h9, 32'hA, 32'h9, 32'hA, 1'b0);
        idle();

        // EX flush blocks capture
        expect_out("flush_e", 32'h9, 32'hA, 32'h9, 32'hA, 1'b0);
        step(1'b1, 64'h0000_000B_0000_000C, 1'b0, 1'b1, 1'b0);

        // Reset mid-flight: clears immediately, write never appears
        expect_out("rst_inflight", 32'hDEAD, 32'hBEEF, 32'h9, 32'hA, 1'b1);
        step(1'b1, 64'h0000_DEAD_0000_BEEF, 1'b0, 1'b0, 1'b0);
        bus.we_e = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        expect_out("rst_async", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        expect_out("rst_held", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_out();
        @(negedge clk);
        rst = 1'b0;
        expect_out("rst_after1", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        expect_out("rst_after2", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();

        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_reg_pipe.md
HILO_REG_PIPE -- requirements
Module: hilo_reg_pipe

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 we_e  input  1  HI/LO write request from EX stage (mult/multu/div/divu/mthi/mtlo).
REQ-004 hilo_e  input  64  EX result {HI[63:32], LO[31:0]}.
REQ-005 stall_e  input  1  EX stalled (multi-cycle divide busy); EX entry not valid for capture.
REQ-006 flush_e  input  1  EX flush; EX entry not valid for capture.
REQ-007 flush_m  input  1  exception flush in MEM; kills MEM entry and blocks EX capture.
REQ-008 hi_o  output  32  HI value seen by EX (drives ALU hi_in).
REQ-009 lo_o  output  32  LO value seen by EX (drives ALU lo_in).
REQ-010 hazard_o  output  1  read-after-write hazard on HI/LO; stall request to hazard unit.
REQ-011 busy_o  output  1  any in-flight write (M or W entry valid).

Function
REQ-012 Three storage levels SHALL exist: M entry (valid_m, data_m 64b), W entry (valid_w, data_w 64b), architectural HI/LO (arch 64b).
REQ-013 Capture: at each edge, valid_m <= we_e & ~stall_e & ~flush_e & ~flush_m; data_m <= hilo_e whenever the capture condition holds, else data_m is held.
REQ-014 Advance: at each edge, valid_w <= valid_m & ~flush_m; data_w <= data_m when valid_m & ~flush_m.
REQ-015 Commit: at each edge where valid_w=1, arch <= data_w; valid_w=0 leaves arch unchanged.
REQ-016 Write latency: request accepted at edge n is forwardable from cycle n+1 and architectural from edge n+2.
REQ-017 Read priority (forwarding on): valid_m ? data_m : valid_w ? data_w : arch; hi_o = selected[63:32], lo_o = selected[31:0], purely combinational.
REQ-018 No bypass from hilo_e to hi_o/lo_o in the same cycle (EX instruction never reads its own write).
REQ-019 flush_m and we_e in the same cycle: M entry killed, EX write dropped, W entry unaffected and commits normally.
REQ-020 Back-to-back writes: each accepted write flows M->W->arch in order; youngest valid entry always wins the read.
REQ-021 busy_o = valid_m | valid_w.
REQ-022 stall_e high for many cycles: in-flight entries continue to drain; no new capture.

Reset
REQ-023 rst asserted (any time, incl. mid-operation) SHALL immediately clear valid_m, valid_w, data_m, data_w, arch to 0.
REQ-024 During and after reset until first commit: hi_o=0, lo_o=0, hazard_o=0, busy_o=0.
REQ-025 Writes in flight when reset asserts are discarded, never committed.

Configuration
REQ-026 Macro HILO_FWD_EN SHALL select forwarding.
REQ-027 HILO_FWD_EN defined: REQ-017 applies; hazard_o tied 0.
REQ-028 HILO_FWD_EN undefined: hi_o/lo_o = arch only; hazard_o = busy_o; all other behaviour identical.

Verification
REQ-029 Reset release, no writes -> hi_o=0x00000000, lo_o=0x00000000, busy_o=0, hazard_o=0.
REQ-030 Cycle 0 we_e=1, hilo_e=0x12345678_9ABCDEF0 -> cycle 1 hi_o=0x12345678, lo_o=0x9ABCDEF0 (FWD on), busy_o=1; cycle 3 busy_o=0, values held.
REQ-031 Writes A=0x1_2 then B=0x3_4 on consecutive cycles -> cycle 1 reads A, cycle 2 reads B, arch ends {0x3,0x4}.
REQ-032 Write 0xAAAA_BBBB accepted at cycle 0, flush_m=1 in cycle 1 -> entry killed; from cycle 2 hi_o/lo_o return prior arch value, busy_o=0.
REQ-033 we_e=1 with stall_e=1 for 5 cycles -> valid_m stays 0, hi_o/lo_o unchanged; stall_e drops with we_e=1 -> captured next edge.
REQ-034 FWD off: write accepted at cycle 0 -> hazard_o=1 cycles 1-2, hi_o/lo_o old value until cycle 3, then new value, hazard_o=0; rst pulse during cycle 1 -> all outputs 0 immediately, write never appears.
